// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - register map, bit indices and FSM states for ccff_loader
package ccff_loader_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_TAIL   = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_DONE     = 3;
  localparam int ST_OVERFLOW = 4;
  localparam int ST_ABORTED  = 5;

  typedef enum logic [2:0] {IDLE, PRESET, LOAD, LOW, HIGH, DONE} state_t;

endpackage

// File: rtl/ccff_word_fifo.sv
// rtl/ccff_word_fifo.sv - first-word fall-through 32-bit bitstream word FIFO
module ccff_word_fifo
  import ccff_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // storage write; a pop in the same cycle frees the slot for a push on a full FIFO
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - Wishbone-fed FPGA configuration chain loader
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int DIV           = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int PRESET_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        preset_o,
  output logic        irq_o
);

  localparam logic [15:0] DIV_LAST    = 16'(DIV - 1);
  localparam logic [15:0] PRESET_LAST = 16'(PRESET_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [31:0] remaining;
  logic [4:0]  bit_idx;
  logic [31:0] shreg;
  logic [31:0] len;
  logic [31:0] tail;
  logic        irq_en;
  logic        done;
  logic        overflow;
  logic        aborted;
  logic [31:0] rd_data;
  logic        req;
  logic        wr;
  logic [2:0]  reg_idx;
  logic        start_go;
  logic        abort_go;
  logic        push;
  logic        pop;
  logic        busy;
  logic [31:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_bits;

  assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr       = req & wbs_we_i;
  assign reg_idx  = wbs_adr_i[4:2];
  assign busy     = (state != IDLE);
  assign start_go = wr && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_START] && !busy;
  assign abort_go = wr && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_ABORT] && busy;
  assign push     = wr && (reg_idx == REG_DATA);

  assign preset_o    = (state == PRESET);
  assign prog_clk_o  = (state == HIGH);
  assign ccff_head_o = shreg[31];
  assign irq_o       = done & irq_en;

  ccff_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (abort_go),
    .wdata (wbs_dat_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // next-state and FIFO pop decision; abort overrides everything outside IDLE
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    if (abort_go) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_go) state_next = (len == '0) ? DONE : PRESET;
        PRESET:  if (cnt == PRESET_LAST) state_next = LOAD;
        LOAD:    if (!fifo_empty) begin
                   pop        = 1'b1;
                   state_next = LOW;
                 end
        LOW:     if (cnt == DIV_LAST) state_next = HIGH;
        HIGH:    if (cnt == DIV_LAST) begin
                   if (remaining == 32'd1)   state_next = DONE;
                   else if (bit_idx == 5'd31) state_next = LOAD;
                   else                       state_next = LOW;
                 end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state, phase counter and shift datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tail      <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (start_go) begin
        remaining <= len;
        bit_idx   <= '0;
      end
      if (pop) begin
        shreg   <= fifo_rdata;
        bit_idx <= '0;
      end
      if (state == HIGH && cnt == '0) tail <= {tail[30:0], ccff_tail_i};
      if (state == HIGH && cnt == DIV_LAST && !abort_go) begin
        remaining <= remaining - 1'b1;
        if (state_next == LOW) begin
          shreg   <= {shreg[30:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

  // control registers and sticky status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en   <= 1'b0;
      len      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (wr && reg_idx == REG_LEN)  len    <= wbs_dat_i;
      if (start_go) begin
        done     <= 1'b0;
        overflow <= 1'b0;
        aborted  <= 1'b0;
      end
      if (state == DONE && !abort_go) done <= 1'b1;
      if (abort_go) aborted <= 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // register read mux
  always_comb begin
    rd_data = 32'h0;
    case (reg_idx)
      REG_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: begin
        rd_data[ST_BUSY]     = busy;
        rd_data[ST_FULL]     = fifo_full;
        rd_data[ST_EMPTY]    = fifo_empty;
        rd_data[ST_DONE]     = done;
        rd_data[ST_OVERFLOW] = overflow;
        rd_data[ST_ABORTED]  = aborted;
      end
      REG_LEN:    rd_data = len;
      REG_TAIL:   rd_data = tail;
      default:    rd_data = 32'h0;
    endcase
  end

  // single-cycle acknowledge with registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else if (req) begin
      wbs_ack_o <= 1'b1;
      wbs_dat_o <= wbs_we_i ? 32'h0 : rd_data;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - self-checking bench for ccff_loader
module tb_ccff_loader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        prog_clk_o;
  logic        ccff_head_o;
  logic        ccff_tail_i = 1'b0;
  logic        preset_o;
  logic        irq_o;

  int          errors = 0;
  int          checks = 0;

  logic        head_q[$];
  int          rise_cyc[$];
  logic        tq[$];
  int          cyc_cnt = 0;
  int          preset_cnt = 0;
  logic        prog_prev = 1'b0;
  logic        lb_prev = 1'b0;
  logic        tail_loop = 1'b0;
  logic        tbit;

  logic [31:0] words[$];
  int          tail_base = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_LEN = 32'h08;
  localparam logic [31:0] A_DATA = 32'h0C, A_TAIL = 32'h10, A_HOLE = 32'h1C;

  ccff_loader dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .prog_clk_o  (prog_clk_o),
    .ccff_head_o (ccff_head_o),
    .ccff_tail_i (ccff_tail_i),
    .preset_o    (preset_o),
    .irq_o       (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // chain-side monitor: records head bits at prog_clk rises and drives the tail stream
  always @(negedge wb_clk_i) begin
    cyc_cnt++;
    if (preset_o === 1'b1) preset_cnt++;
    if (prog_clk_o === 1'b1 && prog_prev !== 1'b1) begin
      head_q.push_back(ccff_head_o);
      rise_cyc.push_back(cyc_cnt);
      if (tail_loop) tbit = lb_prev;
      else           tbit = 1'($urandom);
      ccff_tail_i = tbit;
      tq.push_back(tbit);
      lb_prev = ccff_head_o;
    end
    prog_prev = prog_clk_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat;
    @(negedge wb_clk_i);
    check("ack_high", {31'b0, wbs_ack_o}, 32'd1);
    rdat = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    check("ack_one_cycle", {31'b0, wbs_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic push_words();
    foreach (words[i]) wr(A_DATA, words[i]);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    while (s[3] !== 1'b1 && n < 2000) begin
      rd(A_STATUS, s);
      n++;
    end
    check({tag, "_done_timeout"}, {31'b0, s[3]}, 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int target);
    int n;
    n = 0;
    while (head_q.size() < target && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check({tag, "_rise_timeout"}, {31'b0, head_q.size() >= target}, 32'd1);
  endtask

  // expected chain stream: words MSB first, truncated to len bits
  function automatic int first_bad_bit(input int base, input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = words[i / 32];
      if (head_q[base + i] !== w[31 - (i % 32)]) return i;
    end
    return -1;
  endfunction

  // expected TAIL: the last 32 values driven onto ccff_tail_i since reset, newest in bit 0
  function automatic logic [31:0] exp_tail();
    logic [31:0] acc;
    acc = '0;
    for (int i = tail_base; i < tq.size(); i++) acc = {acc[30:0], tq[i]};
    return acc;
  endfunction

  task automatic run_shift(input string tag, input int len);
    int base;
    logic [31:0] s;
    base = head_q.size();
    push_words();
    wr(A_LEN, len);
    wr(A_CTRL, 32'h5);
    wait_done(tag);
    check({tag, "_edges"}, head_q.size() - base, len);
    check({tag, "_bits"}, first_bad_bit(base, len), 32'hFFFF_FFFF);
    rd(A_STATUS, s);
    check({tag, "_status"}, s, 32'hC);
    rd(A_TAIL, s);
    check({tag, "_tail"}, s, exp_tail());
  endtask

  initial begin
    logic [31:0] r;
    int base;
    int pbase;
    int len;

    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_outs", {28'b0, prog_clk_o, ccff_head_o, preset_o, irq_o}, 32'd0);
    rd(A_STATUS, r);  check("rst_status", r, 32'h4);
    wr(A_LEN, 32'h40);
    rd(A_LEN, r);     check("len_rw", r, 32'h40);
    rd(A_HOLE, r);    check("hole_read", r, 32'h0);
    rd(A_DATA, r);    check("data_read", r, 32'h0);

    // basic shift with fixed words
    wr(A_CTRL, 32'h4);
    rd(A_CTRL, r);    check("irq_en_rw", r, 32'h4);
    words = '{32'hA5A5A5A5, 32'h0F0F0F0F};
    base  = head_q.size();
    pbase = preset_cnt;
    run_shift("basic", 64);
    check("basic_preset_len", preset_cnt - pbase, 32'd16);
    check("basic_period", rise_cyc[base + 1] - rise_cyc[base], 32'd4);
    check("basic_irq", {31'b0, irq_o}, 32'd1);

    // loopback of the head stream through a one-bit delay
    tail_loop = 1'b1;
    words = '{32'hDEADBEEF};
    run_shift("loop", 32);
    rd(A_TAIL, r);
    check("loop_shifted", {1'b0, r[30:0]}, {1'b0, 32'hDEADBEEF >> 1});
    tail_loop = 1'b0;

    // randomized lengths, words and tail stream
    for (int t = 0; t < 3; t++) begin
      len = $urandom_range(33, 224);
      words.delete();
      for (int k = 0; k < (len + 31) / 32; k++) words.push_back($urandom);
      run_shift("rand", len);
    end

    // FIFO starvation stalls prog_clk low until more words arrive
    words = '{$urandom, $urandom, $urandom};
    base = head_q.size();
    wr(A_DATA, words[0]);
    wr(A_LEN, 96);
    wr(A_CTRL, 32'h5);
    wait_rises("starve", base + 32);
    repeat (40) @(negedge wb_clk_i);
    check("starve_edges", head_q.size() - base, 32'd32);
    check("starve_clk_low", {31'b0, prog_clk_o}, 32'd0);
    rd(A_STATUS, r);  check("starve_status", r, 32'h5);
    wr(A_DATA, words[1]);
    wr(A_DATA, words[2]);
    wait_done("starve");
    check("starve_total", head_q.size() - base, 32'd96);
    check("starve_bits", first_bad_bit(base, 96), 32'hFFFF_FFFF);

    // overflow then abort mid-shift
    for (int k = 0; k < 9; k++) wr(A_DATA, $urandom);
    rd(A_STATUS, r);  check("ovf_status", r, 32'h1A);
    base = head_q.size();
    wr(A_LEN, 200);
    wr(A_CTRL, 32'h5);
    wait_rises("abort", base + 5);
    wr(A_CTRL, 32'h6);
    repeat (2) @(negedge wb_clk_i);
    check("abort_outs", {29'b0, prog_clk_o, preset_o, irq_o}, 32'd0);
    rd(A_STATUS, r);  check("abort_status", r, 32'h24);

    // zero-length start completes without edges
    base  = head_q.size();
    pbase = preset_cnt;
    wr(A_LEN, 0);
    wr(A_CTRL, 32'h5);
    rd(A_STATUS, r);  check("len0_status", r, 32'hC);
    check("len0_edges", head_q.size() - base, 32'd0);
    check("len0_preset", preset_cnt - pbase, 32'd0);

    // partial final word
    words = '{$urandom, $urandom};
    run_shift("len40", 40);

    // reset in the middle of a shift
    words = '{$urandom, $urandom};
    base = head_q.size();
    push_words();
    wr(A_LEN, 64);
    wr(A_CTRL, 32'h5);
    wait_rises("midrst", base + 10);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tail_base = tq.size();
    check("midrst_outs", {27'b0, wbs_ack_o, prog_clk_o, ccff_head_o, preset_o, irq_o}, 32'd0);
    rd(A_STATUS, r);  check("midrst_status", r, 32'h4);
    rd(A_TAIL, r);    check("midrst_tail", r, exp_tail());
    rd(A_LEN, r);     check("midrst_len", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
